// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter
// Round-robin arbiter that shares one synchronous FIFO write port between
// NUM_REQ valid/ready producers. Each grant lasts up to BURST_LEN beats.
// A grant ends early if the owner drops valid. A full FIFO stalls the
// owner without costing it its grant.
//
// Ports
//   clk           clock, rising edge
//   rst_n         synchronous active-low reset
//   req_valid     per-requester valid
//   req_data      packed data, requester i at [i*DATA_WIDTH +: DATA_WIDTH]
//   req_ready     per-requester accept (one-hot or zero)
//   fifo_full     FIFO full flag
//   fifo_w_en     FIFO write enable
//   fifo_data_in  FIFO write data
//   grant_id      current owner index (0 while idle)
//   grant_active  high while a requester owns the port
//
// state | meaning
// ------+------------------------------------------------------------
// IDLE  | no owner; pick next valid requester at/after rr_ptr (wrapping)
// OWN   | owner streams beats into the FIFO; stalls while fifo_full
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_LEN  = 4,
   localparam int ID_W  = $clog2(NUM_REQ),
   localparam int CNT_W = $clog2(BURST_LEN + 1)
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_w_en,
   output logic [DATA_WIDTH-1:0]         fifo_data_in,
   output logic [ID_W-1:0]               grant_id,
   output logic                          grant_active
);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_OWN  = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BURST_LEN - 1);
   localparam logic [ID_W-1:0]  LAST_ID   = ID_W'(NUM_REQ - 1);

   state_t                 state_q, state_d;
   logic [ID_W-1:0]        owner_q, owner_d;
   logic [ID_W-1:0]        rr_ptr_q, rr_ptr_d;
   logic [CNT_W-1:0]       burst_cnt_q, burst_cnt_d;

   logic                   pick_found;
   logic [ID_W-1:0]        pick_id;
   logic [ID_W:0]          cand_sum;
   logic                   owner_valid;
   logic [DATA_WIDTH-1:0]  owner_data;
   logic [NUM_REQ-1:0]     owner_onehot;
   logic [ID_W-1:0]        next_ptr;
   logic                   beat;

   // Rotating priority search: offset k from rr_ptr, folded back into range
   // without a modulo so non-power-of-2 NUM_REQ works.
   always_comb begin
      pick_found = 1'b0;
      pick_id    = '0;
      cand_sum   = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_sum = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
         if (cand_sum >= (ID_W+1)'(NUM_REQ)) begin
            cand_sum = cand_sum - (ID_W+1)'(NUM_REQ);
         end
         if (!pick_found && req_valid[cand_sum[ID_W-1:0]]) begin
            pick_found = 1'b1;
            pick_id    = cand_sum[ID_W-1:0];
         end
      end
   end

   always_comb begin
      owner_valid  = 1'b0;
      owner_data   = '0;
      owner_onehot = '0;
      for (int i = 0; i < NUM_REQ; i++) begin
         if (owner_q == ID_W'(i)) begin
            owner_valid     = req_valid[i];
            owner_data      = req_data[i*DATA_WIDTH +: DATA_WIDTH];
            owner_onehot[i] = 1'b1;
         end
      end
   end

   assign next_ptr = (owner_q == LAST_ID) ? '0 : owner_q + 1'b1;

   always_comb begin
      state_d      = state_q;
      owner_d      = owner_q;
      rr_ptr_d     = rr_ptr_q;
      burst_cnt_d  = burst_cnt_q;
      req_ready    = '0;
      fifo_w_en    = 1'b0;
      fifo_data_in = '0;
      grant_id     = '0;
      grant_active = 1'b0;
      beat         = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (pick_found) begin
               owner_d     = pick_id;
               burst_cnt_d = '0;
               state_d     = S_OWN;
            end
         end
         S_OWN: begin
            grant_active = 1'b1;
            grant_id     = owner_q;
            fifo_data_in = owner_data;
            // Gating with rst_n keeps a reset cycle from completing a beat.
            if (rst_n && !fifo_full) begin
               req_ready = owner_onehot;
            end
            beat      = owner_valid && rst_n && !fifo_full;
            fifo_w_en = beat;
            if (beat) begin
               burst_cnt_d = burst_cnt_q + 1'b1;
            end
            if (!owner_valid || (beat && burst_cnt_q == LAST_BEAT)) begin
               state_d  = S_IDLE;
               rr_ptr_d = next_ptr;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q     <= S_IDLE;
         owner_q     <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= '0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         rr_ptr_q    <= rr_ptr_d;
         burst_cnt_q <= burst_cnt_d;
      end
   end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter
// Self-checking bench for fifo_wr_arbiter (NUM_REQ=4, DATA_WIDTH=8,
// BURST_LEN=4). Directed vector table, hand-written multi-cycle sequences,
// then randomized traffic into a depth-8 FIFO model with a cycle-level
// reference of the arbitration rules.
module tb_fifo_wr_arbiter;
   localparam int N  = 4;
   localparam int DW = 8;
   localparam int BL = 4;

   logic          clk = 1'b0;
   logic          rst_n;
   logic [N-1:0]  req_valid;
   logic [N*DW-1:0] req_data;
   logic [N-1:0]  req_ready;
   logic          fifo_full;
   logic          fifo_w_en;
   logic [DW-1:0] fifo_data_in;
   logic [1:0]    grant_id;
   logic          grant_active;

   int n_checks = 0;
   int n_errors = 0;

   fifo_wr_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .req_valid    (req_valid),
      .req_data     (req_data),
      .req_ready    (req_ready),
      .fifo_full    (fifo_full),
      .fifo_w_en    (fifo_w_en),
      .fifo_data_in (fifo_data_in),
      .grant_id     (grant_id),
      .grant_active (grant_active)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] outs();
      return {req_ready, fifo_w_en, grant_id, grant_active, fifo_data_in};
   endfunction

   // Hold reset for a few edges, then check the idle outputs while still in reset.
   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0; req_valid = '0; fifo_full = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1 check("reset_outs", outs(), 16'h0);
   endtask

   // Reference: owner is -1 when nobody holds the port.
   int m_own, m_ptr, m_cnt;

   function automatic logic [15:0] m_predict(logic rn, logic [3:0] v, logic [31:0] d, logic f);
      logic [3:0] rdy = '0;
      logic       we  = 1'b0;
      logic [1:0] gid = '0;
      logic       act = 1'b0;
      logic [7:0] dat = '0;
      if (m_own >= 0) begin
         act = 1'b1;
         gid = m_own[1:0];
         dat = 8'(d >> (8 * m_own));
         if (rn && !f) begin
            rdy = 4'(1 << m_own);
            we  = v[m_own[1:0]];
         end
      end
      return {rdy, we, gid, act, dat};
   endfunction

   task automatic m_update(logic rn, logic [3:0] v, logic f);
      bit found = 0;
      if (!rn) begin
         m_own = -1; m_ptr = 0; m_cnt = 0;
      end else if (m_own < 0) begin
         for (int k = 0; k < N; k++) begin
            int c;
            c = (m_ptr + k) % N;
            if (!found && v[c[1:0]]) begin
               found = 1; m_own = c; m_cnt = 0;
            end
         end
      end else if (!v[m_own[1:0]]) begin
         m_ptr = (m_own + 1) % N; m_own = -1;
      end else if (!f) begin
         m_cnt++;
         if (m_cnt == BL) begin
            m_ptr = (m_own + 1) % N; m_own = -1;
         end
      end
   endtask

   typedef struct packed {
      logic       rst_n;
      logic [3:0] valid;
      logic       full;
      logic [3:0] ready;
      logic       wen;
      logic [1:0] gid;
      logic       act;
      logic [7:0] data;
   } vec_t;

   vec_t vec[18];

   initial begin
      logic [7:0] words[3][10];
      int         wr_idx[3];
      int         rd_idx[3];
      logic [7:0] fq[$];
      int         reads;
      int         sent;
      int         exp_n;
      int         wcount;
      logic       exp_wen;
      logic [7:0] exp_d;

      rst_n = 1'b0; req_valid = '0; req_data = '0; fifo_full = 1'b0;

      // req1 stalls on full mid-burst; req2 drops valid; req3 single beat;
      // req0 granted while full and released on dropping valid.
      vec[0]  = '{1'b1, 4'b0010, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      vec[1]  = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 8'hA1};
      vec[2]  = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 8'hA1};
      vec[3]  = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 8'hA1};
      vec[4]  = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 8'hA1};
      vec[5]  = '{1'b1, 4'b0010, 1'b1, 4'b0000, 1'b0, 2'd1, 1'b1, 8'hA1};
      vec[6]  = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 8'hA1};
      vec[7]  = '{1'b1, 4'b0010, 1'b0, 4'b0010, 1'b1, 2'd1, 1'b1, 8'hA1};
      vec[8]  = '{1'b1, 4'b1110, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      vec[9]  = '{1'b1, 4'b1100, 1'b0, 4'b0100, 1'b1, 2'd2, 1'b1, 8'hA2};
      vec[10] = '{1'b1, 4'b1000, 1'b0, 4'b0100, 1'b0, 2'd2, 1'b1, 8'hA2};
      vec[11] = '{1'b1, 4'b1000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      vec[12] = '{1'b1, 4'b1000, 1'b0, 4'b1000, 1'b1, 2'd3, 1'b1, 8'hA3};
      vec[13] = '{1'b1, 4'b0000, 1'b0, 4'b1000, 1'b0, 2'd3, 1'b1, 8'hA3};
      vec[14] = '{1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};
      vec[15] = '{1'b1, 4'b0001, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 8'hA0};
      vec[16] = '{1'b1, 4'b0000, 1'b1, 4'b0000, 1'b0, 2'd0, 1'b1, 8'hA0};
      vec[17] = '{1'b1, 4'b0000, 1'b0, 4'b0000, 1'b0, 2'd0, 1'b0, 8'h00};

      do_reset();
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0};
      for (int i = 0; i < 18; i++) begin
         @(negedge clk);
         rst_n = vec[i].rst_n; req_valid = vec[i].valid; fifo_full = vec[i].full;
         #1 check($sformatf("vec%0d", i), outs(),
                  {vec[i].ready, vec[i].wen, vec[i].gid, vec[i].act, vec[i].data});
      end

      // Single requester: 4 writes, one idle gap, re-granted via wrap.
      do_reset();
      req_data = '0; sent = 0; exp_n = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         rst_n = 1'b1; fifo_full = 1'b0; req_valid = 4'b0001;
         req_data[7:0] = 8'(8'h10 + sent);
         exp_wen = (c != 0) && (c != 5);
         exp_d   = exp_wen ? 8'(8'h10 + exp_n) : 8'h00;
         #1 check($sformatf("single_c%0d", c), {fifo_w_en, fifo_data_in}, {exp_wen, exp_d});
         if (req_ready[0]) sent++;
         if (exp_wen) exp_n++;
      end

      // Reset during req0's third beat: no write, then a fresh burst.
      do_reset();
      req_data = '0; sent = 0; exp_n = 0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         rst_n = (c != 3); fifo_full = 1'b0; req_valid = 4'b0001;
         req_data[7:0] = 8'(8'h20 + sent);
         exp_wen = (c == 1) || (c == 2) || (c >= 5 && c <= 8);
         exp_d   = exp_wen ? 8'(8'h20 + exp_n) : 8'h00;
         #1;
         if (c == 3)      check("rst_mid_burst", {req_ready, fifo_w_en}, 5'h0);
         else if (c == 4) check("after_rst_idle", outs(), 16'h0);
         else             check($sformatf("rst_seq_c%0d", c), {fifo_w_en, fifo_data_in}, {exp_wen, exp_d});
         if (req_ready[0] && req_valid[0]) sent++;
         if (exp_wen) exp_n++;
      end

      // All requesters valid: grants 0,1,2,3,0 with one gap cycle each.
      do_reset();
      req_data = {8'hA3, 8'hA2, 8'hA1, 8'hA0}; wcount = 0;
      for (int c = 0; c < 22; c++) begin
         @(negedge clk);
         rst_n = 1'b1; fifo_full = 1'b0; req_valid = 4'b1111;
         #1;
         if (c % 5 == 0) check($sformatf("rr_c%0d", c), {grant_active, grant_id, fifo_w_en}, 4'h0);
         else            check($sformatf("rr_c%0d", c), {grant_active, grant_id, fifo_w_en},
                               {1'b1, 2'((c / 5) % 4), 1'b1});
         if (c < 20 && fifo_w_en) wcount++;
      end
      check("rr_writes_in_20", wcount, 16);

      // Random traffic from req0-2 into a depth-8 FIFO with slow reads.
      do_reset();
      m_own = -1; m_ptr = 0; m_cnt = 0;
      reads = 0;
      for (int i = 0; i < 3; i++) begin
         wr_idx[i] = 0; rd_idx[i] = 0;
         for (int k = 0; k < 10; k++) words[i][k] = {2'(i), 6'($urandom_range(0, 63))};
      end
      for (int cyc = 0; cyc < 4000 && reads < 30; cyc++) begin
         logic [15:0] exp_o;
         @(negedge clk);
         rst_n = ($urandom_range(0, 79) != 0);
         for (int i = 0; i < N; i++) begin
            if (i < 3 && wr_idx[i] < 10) begin
               req_valid[i] = ($urandom_range(0, 3) != 0);
               req_data[i*DW +: DW] = words[i][wr_idx[i]];
            end else begin
               req_valid[i] = 1'b0;
               req_data[i*DW +: DW] = 8'($urandom);
            end
         end
         fifo_full = (fq.size() >= 8);
         #1;
         exp_o = m_predict(rst_n, req_valid, req_data, fifo_full);
         check($sformatf("rnd_c%0d", cyc), outs(), exp_o);
         check("no_write_while_full", fifo_w_en & fifo_full, 1'b0);
         m_update(rst_n, req_valid, fifo_full);
         if (fq.size() > 0 && $urandom_range(0, 2) == 0) begin
            logic [7:0] w, expw;
            int src;
            w = fq.pop_front();
            src = int'(w[7:6]);
            expw = (src < 3 && rd_idx[src] < 10) ? words[src][rd_idx[src]] : ~w;
            check($sformatf("fifo_order_%0d", reads), w, expw);
            if (src < 3) rd_idx[src]++;
            reads++;
         end
         if (fifo_w_en && fq.size() < 8) fq.push_back(fifo_data_in);
         for (int i = 0; i < 3; i++) if (req_valid[i] && req_ready[i]) wr_idx[i]++;
      end
      check("fifo_reads_total", reads, 30);
      check("fifo_accepted_total", wr_idx[0] + wr_idx[1] + wr_idx[2], 30);
      check("fifo_drained", fq.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
